// File: rtl/alpha_rst_pkg.sv
`default_nettype none
// ============================================================================
//  alpha_rst_pkg
//  Shared state and reset-cause encodings for the alpha reset sequencer.
//  Revision: 1.0
// ============================================================================
package alpha_rst_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      STRETCH = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } rst_state_e;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'b00,
      CAUSE_SW  = 2'b01,
      CAUSE_WDT = 2'b10
   } rst_cause_e;

endpackage
`default_nettype wire

// File: rtl/alpha_rst_sync.sv
`default_nettype none
// ============================================================================
//  alpha_rst_sync
//  Reset-release synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
//  Revision: 1.0
// ============================================================================
module alpha_rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic rst_sync
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/alpha_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  alpha_reset_sequencer
//  Synchronised POR, stretch, staggered channel release, SW reset and watchdog.
//  Revision: 1.0
// ============================================================================
module alpha_reset_sequencer
   import alpha_rst_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 4,
   parameter int STAGGER     = 2,
   parameter int WDT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sw_rst_req,
   input  logic              wdt_en,
   input  logic              wdt_kick,
   input  logic [WDT_W-1:0]  wdt_limit,
   output logic [NUM_CH-1:0] rst_out,
   output logic              ready,
   output logic [1:0]        cause,
   output logic [WDT_W-1:0]  wdt_count
);

   localparam int c_CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam int c_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   rst_state_e          r_state,   w_state_nxt;
   rst_cause_e          r_cause,   w_cause_nxt;
   logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
   logic [c_IDX_W-1:0]  r_idx,     w_idx_nxt;
   logic [NUM_CH-1:0]   r_rst_out, w_rst_out_nxt;
   logic [WDT_W-1:0]    r_wdt_cnt, w_wdt_nxt;
   logic                w_rst_sync;
   logic                w_wdt_active;
   logic                w_wdt_expire;
   logic                w_sw_trig;

   alpha_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .rst_sync (w_rst_sync)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= alpha_rst_pkg::ASSERT;
         r_cause   <= CAUSE_POR;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rst_out <= '1;
         r_wdt_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cause   <= w_cause_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_rst_out <= w_rst_out_nxt;
         r_wdt_cnt <= w_wdt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cause_nxt   = r_cause;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_rst_out_nxt = r_rst_out;
      w_wdt_nxt     = '0;

      w_wdt_active = (r_state == alpha_rst_pkg::RUN) && wdt_en && (wdt_limit != '0);
      // A kick on the expiry edge wins over the timeout.
      w_wdt_expire = w_wdt_active && !wdt_kick && (r_wdt_cnt == wdt_limit);
      w_sw_trig    = sw_rst_req && (r_state != alpha_rst_pkg::ASSERT);

      if (w_sw_trig || w_wdt_expire) begin
         w_state_nxt   = alpha_rst_pkg::ASSERT;
         w_cause_nxt   = w_sw_trig ? CAUSE_SW : CAUSE_WDT;
         w_rst_out_nxt = '1;
         w_cnt_nxt     = '0;
         w_idx_nxt     = '0;
      end else begin
         case (r_state)
            alpha_rst_pkg::ASSERT: begin
               w_rst_out_nxt = '1;
               if (w_rst_sync) begin
                  w_state_nxt = alpha_rst_pkg::STRETCH;
                  w_cnt_nxt   = c_CNT_W'(STRETCH - 1);
               end
            end
            alpha_rst_pkg::STRETCH: begin
               if (r_cnt == '0) begin
                  w_rst_out_nxt[0] = 1'b0;
                  if (NUM_CH == 1) begin
                     w_state_nxt = alpha_rst_pkg::RUN;
                  end else begin
                     w_state_nxt = alpha_rst_pkg::RELEASE;
                     w_idx_nxt   = c_IDX_W'(1);
                     w_cnt_nxt   = c_CNT_W'(STAGGER - 1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            alpha_rst_pkg::RELEASE: begin
               if (r_cnt == '0) begin
                  w_rst_out_nxt[r_idx] = 1'b0;
                  if (r_idx == c_IDX_W'(NUM_CH - 1)) begin
                     w_state_nxt = alpha_rst_pkg::RUN;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                     w_cnt_nxt = c_CNT_W'(STAGGER - 1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: begin
               // Saturating count so a late limit change can never wrap it.
               if (w_wdt_active) begin
                  if (wdt_kick) begin
                     w_wdt_nxt = '0;
                  end else if (r_wdt_cnt != '1) begin
                     w_wdt_nxt = r_wdt_cnt + 1'b1;
                  end else begin
                     w_wdt_nxt = r_wdt_cnt;
                  end
               end
            end
         endcase
      end
   end

   assign rst_out   = r_rst_out;
   assign ready     = (r_state == alpha_rst_pkg::RUN);
   assign cause     = r_cause;
   assign wdt_count = r_wdt_cnt;

endmodule
`default_nettype wire

// File: doc/alpha_reset_sequencer.md
# alpha_reset_sequencer

Parametrised reset sequencer for the alpha processor. It is the synthesizable successor to the single hand-pulsed active-high reset that the processor bench drives today. It takes one asynchronous active-low reset, synchronises its release, and holds it for a programmable stretch. It then releases NUM_CH active-high reset channels (core, memories, peripherals, etc.) in a staggered order. It adds software-requested reset and a watchdog, and records the cause of the last reset.

## Interface
Parameters:
- NUM_CH, 4: number of reset output channels; minimum 1.
- SYNC_STAGES, 2: depth of the reset-release synchroniser; minimum 2.
- STRETCH, 4: cycles spent in STRETCH before channel 0 is released; minimum 1.
- STAGGER, 2: cycles between successive channel releases; minimum 1.
- WDT_W, 16: watchdog counter and limit width.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset; assertion is immediate, deassertion passes through the synchroniser.
- sw_rst_req  in  1  software reset request, sampled every edge.
- wdt_en  in  1  watchdog enable.
- wdt_kick  in  1  watchdog service strobe.
- wdt_limit  in  WDT_W  watchdog timeout in cycles; 0 disables the watchdog.
- rst_out  out  NUM_CH  active-high channel resets.
- ready  out  1  high when every channel is released (state RUN).
- cause  out  2  cause of the last reset: 00 POR, 01 SW, 10 WDT.
- wdt_count  out  WDT_W  current watchdog count.

## Operation
- Reset values while reset=0:
  - rst_out all 1, ready 0, cause 00, wdt_count 0.
  - state ASSERT, synchroniser cleared.
- States are ASSERT, STRETCH, RELEASE, RUN.
- ASSERT:
  - all rst_out are 1.
  - On POR, the state leaves ASSERT on the first edge where rst_sync=1.
  - On an internal trigger, ASSERT lasts exactly one cycle.
  - Next state is STRETCH.
- STRETCH:
  - a down-counter loaded with STRETCH counts to zero.
  - The state then goes to RELEASE and clears rst_out[0] on that edge.
- RELEASE:
  - rst_out[k] clears STAGGER edges after rst_out[k-1].
  - When rst_out[NUM_CH-1] clears, the state goes to RUN and ready rises on the same edge.
  - With NUM_CH=1, the STRETCH exit goes directly to RUN.
- Channels, once cleared, stay cleared until the next trigger; rst_out is monotonic within a sequence.
- Internal triggers:
  - sw_rst_req=1 in any state other than ASSERT.
  - Watchdog expiry in RUN.
- On a trigger edge:
  - all rst_out go to 1 and ready goes to 0.
  - cause is updated and the state becomes ASSERT.
  - wdt_count clears.
- Watchdog:
  - Active only in RUN with wdt_en=1 and wdt_limit≠0; otherwise wdt_count is held at 0.
  - wdt_kick=1 clears the count to 0; otherwise the count increments.
  - Expiry occurs when the registered wdt_count equals wdt_limit at a sampling edge.
  - The counter saturates and never wraps; reaching the limit always triggers.
- Simultaneous events:
  - sw_rst_req together with watchdog expiry gives cause SW.
  - wdt_kick together with expiry: the kick wins and no trigger occurs.
  - reset=0 overrides everything asynchronously; cause returns to POR.
- sw_rst_req held high keeps the block alternating ASSERT→STRETCH→ASSERT; no channel is released while the request is held.
- A trigger during STRETCH or RELEASE re-asserts any channels already released and restarts the sequence.

## Timing
- POR: let E0 be the first rising edge with reset=1.
  - rst_sync is 1 after edge E(SYNC_STAGES−1).
  - STRETCH is entered at E(SYNC_STAGES).
  - rst_out[k] falls at E(SYNC_STAGES+STRETCH+k·STAGGER).
  - ready rises with the last channel.
  - Defaults: channels fall at E6, E8, E10, E12; ready rises at E12.
- Internal trigger sampled at edge T:
  - rst_out is all 1 after T.
  - STRETCH is entered at T+1.
  - rst_out[0] falls at T+1+STRETCH (T+5 by default).
- Watchdog, with RUN entered at edge R, no kicks, limit L:
  - wdt_count equals L after R+L.
  - The trigger is sampled at R+L+1.
- All outputs are registered; nothing combinational runs from input to output.

## Structure
- Package alpha_rst_pkg:
  - rst_state_e {ASSERT, STRETCH, RELEASE, RUN}.
  - rst_cause_e {CAUSE_POR=2'b00, CAUSE_SW=2'b01, CAUSE_WDT=2'b10}.
- Sub-module alpha_rst_sync:
  - SYNC_STAGES flop chain, asynchronously cleared by reset, D input tied to 1, output rst_sync.
- Top level holds the FSM, the stretch/stagger counter (width $clog2 of max(STRETCH, STAGGER)+1), the channel index, the watchdog and the cause register.

## Test plan
- POR with defaults: reset low for 3 cycles, then high → rst_out 1111→1110 at E6, 1100 at E8, 1000 at E10, 0000 and ready=1 at E12; cause=00.
- SW reset in RUN: one-cycle sw_rst_req at edge T → rst_out=1111 and ready=0 after T; cause=01; rst_out[0] falls at T+5; ready returns at T+11.
- Watchdog, wdt_en=1, limit=10, no kicks → trigger at R+11 and cause=10; with a kick every 8 cycles, no trigger over 1000 cycles.
- Simultaneous events: sw_rst_req together with expiry → cause=01; kick together with expiry → no trigger and wdt_count=0.
- Reset mid-operation: reset=0 during RELEASE (after rst_out=1100) → rst_out=1111 immediately and cause=00; release resumes as a full POR sequence.
- Parameter sweep NUM_CH=1, STRETCH=1, STAGGER=3, SYNC_STAGES=3 → rst_out[0] and ready change at E4; limit=0 never fires.
